// File: rtl/decim_accum_buffer.sv
// Block accumulator/decimator: sums N = 2^dec_sel accepted samples and queues
// {sum, log2(N)} in a 2-entry valid/ready FIFO, counting results that find it full.
module decim_accum_buffer #(
   parameter  int DW     = 8,
   parameter  int MAXLOG = 3,
   localparam int SW     = DW + MAXLOG
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [1:0]    dec_sel,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [SW-1:0] out_sum,
   output logic [DW-1:0] out_avg,
   output logic [7:0]    drop_cnt,
   output logic          busy
);

   localparam logic [MAXLOG:0] ONE_C = {{MAXLOG{1'b0}}, 1'b1};

   function automatic logic [DW-1:0] avg_f(input logic [SW-1:0] s, input logic [1:0] l);
      logic [SW-1:0] t;
      t = s >> l;
      return t[DW-1:0];
   endfunction

   logic [SW-1:0]     acc_q, acc_d;
   logic [MAXLOG-1:0] cnt_q, cnt_d;
   logic [1:0]        blk_log_q, blk_log_d;
   logic [SW-1:0]     mem_sum_q [2];
   logic [1:0]        mem_log_q [2];
   logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [1:0]        fcnt_q, fcnt_d;
   logic [7:0]        drop_q, drop_d;
   logic              out_valid_q, busy_q;
   logic [SW-1:0]     out_sum_q;
   logic [DW-1:0]     out_avg_q;

   logic [SW-1:0]     res_sum_s;
   logic [1:0]        res_log_s;
   logic [MAXLOG:0]   last_idx_s;
   logic              push_s, pop_s, wr_en_s;
   logic [SW-1:0]     head_sum_s;
   logic [1:0]        head_log_s;

   // Accumulator: the block size is taken from dec_sel only on a block's first sample.
   always_comb begin
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      blk_log_d  = blk_log_q;
      push_s     = 1'b0;
      res_sum_s  = acc_q + {{MAXLOG{1'b0}}, in_data};
      res_log_s  = (cnt_q == {MAXLOG{1'b0}}) ? dec_sel : blk_log_q;
      last_idx_s = (ONE_C << res_log_s) - ONE_C;
      if (!en) begin
         acc_d = {SW{1'b0}};
         cnt_d = {MAXLOG{1'b0}};
      end else if (in_valid) begin
         blk_log_d = res_log_s;
         if ({1'b0, cnt_q} == last_idx_s) begin
            push_s = 1'b1;
            acc_d  = {SW{1'b0}};
            cnt_d  = {MAXLOG{1'b0}};
         end else begin
            acc_d = res_sum_s;
            cnt_d = cnt_q + {{(MAXLOG-1){1'b0}}, 1'b1};
         end
      end else begin
         acc_d = acc_q;
         cnt_d = cnt_q;
      end
   end

   // FIFO control; a full FIFO still accepts a push when it pops on the same edge.
   always_comb begin
      pop_s    = (fcnt_q != 2'd0) && out_ready;
      wr_en_s  = push_s && ((fcnt_q != 2'd2) || pop_s);
      fcnt_d   = fcnt_q + {1'b0, wr_en_s} - {1'b0, pop_s};
      rd_ptr_d = rd_ptr_q ^ pop_s;
      wr_ptr_d = wr_ptr_q ^ wr_en_s;
      if (push_s && !wr_en_s && (drop_q != 8'd255)) begin
         drop_d = drop_q + 8'd1;
      end else begin
         drop_d = drop_q;
      end
      // The entry being written this edge may already be next cycle's head.
      if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
         head_sum_s = res_sum_s;
         head_log_s = res_log_s;
      end else begin
         head_sum_s = mem_sum_q[rd_ptr_d];
         head_log_s = mem_log_q[rd_ptr_d];
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q        <= {SW{1'b0}};
         cnt_q        <= {MAXLOG{1'b0}};
         blk_log_q    <= 2'd0;
         mem_sum_q[0] <= {SW{1'b0}};
         mem_sum_q[1] <= {SW{1'b0}};
         mem_log_q[0] <= 2'd0;
         mem_log_q[1] <= 2'd0;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         fcnt_q       <= 2'd0;
         drop_q       <= 8'd0;
         out_valid_q  <= 1'b0;
         out_sum_q    <= {SW{1'b0}};
         out_avg_q    <= {DW{1'b0}};
         busy_q       <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         blk_log_q <= blk_log_d;
         if (wr_en_s) begin
            mem_sum_q[wr_ptr_q] <= res_sum_s;
            mem_log_q[wr_ptr_q] <= res_log_s;
         end
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         fcnt_q      <= fcnt_d;
         drop_q      <= drop_d;
         out_valid_q <= (fcnt_d != 2'd0);
         out_sum_q   <= (fcnt_d != 2'd0) ? head_sum_s : {SW{1'b0}};
         out_avg_q   <= (fcnt_d != 2'd0) ? avg_f(head_sum_s, head_log_s) : {DW{1'b0}};
         busy_q      <= (cnt_d != {MAXLOG{1'b0}});
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_avg   = out_avg_q;
   assign drop_cnt  = drop_q;
   assign busy      = busy_q;

endmodule

// File: doc/decim_accum_buffer.md
Name: decim_accum_buffer

Overview:
- Downstream stage of the 8-bit FIR output; consumes one filtered sample per clock when valid.
- Accumulates blocks of N consecutive samples (N = 1, 2, 4 or 8, selected at runtime) and emits the block sum and the block average.
- Results pass through a 2-entry output FIFO with a valid/ready handshake, so a stalled consumer does not lose results immediately.
- Results that cannot enter the FIFO are counted as drops.

Parameters:
- DW, 8, input sample width (unsigned).
- MAXLOG, 3, log2 of the maximum decimation factor (N max = 8).
- SW, DW+MAXLOG (11), output sum width; derived, must not be overridden.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  block enable; 0 aborts and holds the accumulator cleared.
- dec_sel  input  2  log2(N): 0->N=1, 1->N=2, 2->N=4, 3->N=8.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DW  unsigned sample.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_sum  output  SW  block sum at the FIFO head.
- out_avg  output  DW  block average at the FIFO head: sum >> log2(N) of that block (truncating).
- drop_cnt  output  8  count of dropped results, saturates at 255.
- busy  output  1  1 while a partial block is accumulating (cnt != 0).

Behaviour:
- Reset (async): acc, cnt, latched log, FIFO pointers/count, drop_cnt all 0; out_valid=0, out_sum=0, out_avg=0, busy=0.
- Accepted sample: in_valid & en on a clock edge.
- Block start (cnt==0 and accepted sample): latch dec_sel into blk_log. dec_sel changes mid-block have no effect until the next block.
- Accumulation:
  - Each accepted sample adds in_data to acc and increments cnt.
  - At the sample where cnt == 2^blk_log - 1, the result is acc + in_data (full SW width, no overflow possible).
  - The result and blk_log are pushed into the FIFO on that same edge; acc and cnt clear.
  - Latency: out_valid rises the cycle after the final sample edge if the FIFO was empty.
- N=1: every accepted sample is a result; out_sum = zero-extended in_data, out_avg = in_data.
- in_valid=0 with en=1: hold acc/cnt (gaps allowed inside a block).
- en=0: acc and cnt clear on the next edge (partial block discarded, not counted as a drop); FIFO contents and handshake unaffected.
- FIFO:
  - 2 entries, each holding {sum, blk_log}.
  - out_sum/out_avg are driven from the head entry and are stable while out_valid & !out_ready.
  - Pop when out_valid & out_ready.
  - When out_valid=0, out_sum/out_avg show 0.
- Push with FIFO full:
  - If a pop occurs on the same edge, the push succeeds (count stays 2).
  - Otherwise the result is discarded, drop_cnt increments (saturating at 255), and acc/cnt still clear.
- Simultaneous push and pop with FIFO count 1: count stays 1; the new entry becomes head on the next cycle.
- Push into an empty FIFO with out_ready=1: no bypass; out_valid rises next cycle.
- busy = (cnt != 0), registered.
- Reset asserted mid-block or with the FIFO non-empty: everything clears immediately; no residual out_valid after rst deasserts.

Test Plan:
- Reset then N=4 (dec_sel=2), en=1, in_valid continuous, samples 10,20,30,40 -> one cycle after the 4th edge: out_valid=1, out_sum=100, out_avg=25; busy=1 during samples 2-4, 0 after.
- N=8, eight samples of 255 -> out_sum=2040, out_avg=255; no overflow.
- N=2, out_ready=0, samples 1..8 -> FIFO holds sums 3 and 7; sums 11 and 15 dropped; drop_cnt=2. Then out_ready=1 -> 3 then 7 delivered in order, out_valid falls.
- N=4, samples 5,5 then en=0 for one cycle, then 8,8,8,8 -> single result out_sum=32; drop_cnt unchanged.
- N=1 with in_valid toggling 1,0,1 (samples 7, x, 9) and out_ready=1 -> outputs 7 and 9, out_avg=out_sum; change dec_sel from 0 to 3 mid-stream -> the next block counts 8 samples.
- Fill the FIFO (2 entries), then assert rst mid-block -> out_valid=0, drop_cnt=0, busy=0 immediately; the first result after reset reflects only post-reset samples.
